// File: rtl/epwm_pkg.sv
// Shared constants and types for the ePWM register block and its PWM core.
package epwm_pkg;

   localparam logic [3:0] EPWM_CTRL   = 4'h0;
   localparam logic [3:0] EPWM_PERIOD = 4'h4;
   localparam logic [3:0] EPWM_CMPA   = 4'h8;
   localparam logic [3:0] EPWM_CMPB   = 4'hC;

   localparam int unsigned CTRL_ENABLE_BIT   = 0;
   localparam int unsigned CTRL_INVERT_B_BIT = 1;

   localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

   typedef logic [15:0] cnt_t;

   function automatic logic [1:0] reg_index(input logic [3:0] byte_addr);
      return byte_addr[3:2];
   endfunction

endpackage

// File: rtl/epwm_core.sv
// Two-channel PWM generator: up-counter with period wrap, shadowed period/compare
// values that reload only at wrap (or continuously while disabled), registered outputs.
module epwm_core
   import epwm_pkg::*;
(
   input  logic clk_i,
   input  logic rst_i,
   input  logic enable_i,
   input  logic invert_b_i,
   input  cnt_t period_i,
   input  cnt_t cmpa_i,
   input  cnt_t cmpb_i,
   output logic pwm_a_o,
   output logic pwm_b_o,
   output logic period_irq_o
);

   cnt_t cnt_q, cnt_d;
   cnt_t per_q, per_d;
   cnt_t cmpa_q, cmpa_d;
   cnt_t cmpb_q, cmpb_d;
   logic pwm_a_q, pwm_a_d;
   logic pwm_b_q, pwm_b_d;
   logic irq_q, irq_d;
   logic wrap;

   always_comb begin
      cnt_d   = cnt_q;
      per_d   = per_q;
      cmpa_d  = cmpa_q;
      cmpb_d  = cmpb_q;
      pwm_a_d = 1'b0;
      pwm_b_d = 1'b0;
      irq_d   = 1'b0;
      wrap    = (cnt_q == per_q);
      if (!enable_i) begin
         // Track software values continuously so enabling starts with fresh settings.
         cnt_d  = '0;
         per_d  = period_i;
         cmpa_d = cmpa_i;
         cmpb_d = cmpb_i;
      end else begin
         pwm_a_d = (cnt_q < cmpa_q);
         pwm_b_d = (cnt_q < cmpb_q) ^ invert_b_i;
         irq_d   = wrap;
         if (wrap) begin
            cnt_d  = '0;
            per_d  = period_i;
            cmpa_d = cmpa_i;
            cmpb_d = cmpb_i;
         end else begin
            cnt_d = cnt_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q   <= '0;
         per_q   <= '0;
         cmpa_q  <= '0;
         cmpb_q  <= '0;
         pwm_a_q <= 1'b0;
         pwm_b_q <= 1'b0;
         irq_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         per_q   <= per_d;
         cmpa_q  <= cmpa_d;
         cmpb_q  <= cmpb_d;
         pwm_a_q <= pwm_a_d;
         pwm_b_q <= pwm_b_d;
         irq_q   <= irq_d;
      end
   end

   assign pwm_a_o      = pwm_a_q;
   assign pwm_b_o      = pwm_b_q;
   assign period_irq_o = irq_q;

endmodule

// File: rtl/epwm_axil_regs.sv
// AXI4-Lite slave with four 32-bit ePWM control registers (CTRL, PERIOD, CMPA, CMPB)
// driving the epwm_core PWM generator.
module epwm_axil_regs
   import epwm_pkg::*;
#(
   parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
   input  logic                              s00_axi_aclk,
   input  logic                              s00_axi_areset,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
   input  logic [2:0]                        s00_axi_awprot,
   input  logic                              s00_axi_awvalid,
   output logic                              s00_axi_awready,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
   input  logic [(C_S_AXI_DATA_WIDTH/8)-1:0] s00_axi_wstrb,
   input  logic                              s00_axi_wvalid,
   output logic                              s00_axi_wready,
   output logic [1:0]                        s00_axi_bresp,
   output logic                              s00_axi_bvalid,
   input  logic                              s00_axi_bready,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
   input  logic [2:0]                        s00_axi_arprot,
   input  logic                              s00_axi_arvalid,
   output logic                              s00_axi_arready,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
   output logic [1:0]                        s00_axi_rresp,
   output logic                              s00_axi_rvalid,
   input  logic                              s00_axi_rready,
   output logic                              pwm_a,
   output logic                              pwm_b,
   output logic                              period_irq
);

   localparam int unsigned StrbW = C_S_AXI_DATA_WIDTH / 8;
   typedef logic [C_S_AXI_DATA_WIDTH-1:0] data_t;

   data_t      regs_q [4];
   data_t      regs_d [4];
   data_t      rdata_q, rdata_d;
   logic       awready_q, awready_d;
   logic       bvalid_q, bvalid_d;
   logic       arready_q, arready_d;
   logic       rvalid_q, rvalid_d;
   logic       wr_en, rd_en;
   logic [1:0] wr_idx, rd_idx;
   logic       unused_ok;

   always_comb begin
      wr_idx    = s00_axi_awaddr[3:2];
      rd_idx    = s00_axi_araddr[3:2];
      // AW and W are accepted together; a single flop serves both ready outputs.
      wr_en     = awready_q && s00_axi_awvalid && s00_axi_wvalid;
      rd_en     = arready_q && s00_axi_arvalid;
      awready_d = s00_axi_awvalid && s00_axi_wvalid && !awready_q && !bvalid_q;
      arready_d = s00_axi_arvalid && !arready_q && !rvalid_q;

      bvalid_d = bvalid_q;
      if (wr_en) begin
         bvalid_d = 1'b1;
      end else if (s00_axi_bready) begin
         bvalid_d = 1'b0;
      end

      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      if (rd_en) begin
         rvalid_d = 1'b1;
         rdata_d  = regs_q[rd_idx];
      end else if (s00_axi_rready) begin
         rvalid_d = 1'b0;
      end

      for (int i = 0; i < 4; i++) begin
         regs_d[i] = regs_q[i];
      end
      if (wr_en) begin
         for (int unsigned b = 0; b < StrbW; b++) begin
            if (s00_axi_wstrb[b]) begin
               regs_d[wr_idx][8*b +: 8] = s00_axi_wdata[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
      if (s00_axi_areset) begin
         for (int i = 0; i < 4; i++) begin
            regs_q[i] <= '0;
         end
         rdata_q   <= '0;
         awready_q <= 1'b0;
         bvalid_q  <= 1'b0;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            regs_q[i] <= regs_d[i];
         end
         rdata_q   <= rdata_d;
         awready_q <= awready_d;
         bvalid_q  <= bvalid_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
      end
   end

   assign s00_axi_awready = awready_q;
   assign s00_axi_wready  = awready_q;
   assign s00_axi_bvalid  = bvalid_q;
   assign s00_axi_bresp   = AXI_RESP_OKAY;
   assign s00_axi_arready = arready_q;
   assign s00_axi_rvalid  = rvalid_q;
   assign s00_axi_rdata   = rdata_q;
   assign s00_axi_rresp   = AXI_RESP_OKAY;

   assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0],
                        s00_axi_araddr[1:0]};

   epwm_core u_core (
      .clk_i        (s00_axi_aclk),
      .rst_i        (s00_axi_areset),
      .enable_i     (regs_q[reg_index(EPWM_CTRL)][CTRL_ENABLE_BIT]),
      .invert_b_i   (regs_q[reg_index(EPWM_CTRL)][CTRL_INVERT_B_BIT]),
      .period_i     (regs_q[reg_index(EPWM_PERIOD)][15:0]),
      .cmpa_i       (regs_q[reg_index(EPWM_CMPA)][15:0]),
      .cmpb_i       (regs_q[reg_index(EPWM_CMPB)][15:0]),
      .pwm_a_o      (pwm_a),
      .pwm_b_o      (pwm_b),
      .period_irq_o (period_irq)
   );

endmodule

// File: doc/epwm_axil_regs.md
# epwm_axil_regs

AXI4-Lite responder that terminates the bus master's register traffic for the ePWM IP. It holds four 32-bit control registers and drives a two-channel PWM generator from them. Period and compare values are double-buffered so software writes take effect only at a period boundary. It sits directly behind the interconnect as the `S00_AXI` slave of the ePWM block.

## Interface
Parameters:
- `C_S_AXI_DATA_WIDTH`, 32: bus data width; only 32 is supported.
- `C_S_AXI_ADDR_WIDTH`, 4: byte-address width; bits [3:2] select the register.

Ports:
- `s00_axi_aclk`  in  1  single clock for bus and PWM logic.
- `s00_axi_areset`  in  1  asynchronous, active-high reset.
- `s00_axi_awaddr`  in  4  write address; `s00_axi_awprot`  in  3  ignored.
- `s00_axi_awvalid` in 1, `s00_axi_awready` out 1: write-address handshake.
- `s00_axi_wdata`  in  32  write data; `s00_axi_wstrb`  in  4  byte enables.
- `s00_axi_wvalid` in 1, `s00_axi_wready` out 1: write-data handshake.
- `s00_axi_bresp`  out  2  always 2'b00 (OKAY).
- `s00_axi_bvalid` out 1, `s00_axi_bready` in 1: write-response handshake.
- `s00_axi_araddr`  in  4  read address; `s00_axi_arprot`  in  3  ignored.
- `s00_axi_arvalid` in 1, `s00_axi_arready` out 1: read-address handshake.
- `s00_axi_rdata`  out  32  read data; `s00_axi_rresp`  out  2  always 2'b00.
- `s00_axi_rvalid` out 1, `s00_axi_rready` in 1: read-data handshake.
- `pwm_a`, `pwm_b`  out  1  PWM outputs.
- `period_irq`  out  1  one-cycle pulse at each counter wrap.

## Operation
Register map. All four registers are fully read/write, and all 32 bits are stored and read back.
- 0x0 CTRL: bit0 is `enable`; bit1 is `invert_b`.
- 0x4 PERIOD: bits [15:0] are used.
- 0x8 CMPA: bits [15:0] are used.
- 0xC CMPB: bits [15:0] are used.

Write path:
- `awready` and `wready` rise together for exactly one cycle when `awvalid && wvalid && !awready && !bvalid`.
- On that handshake edge, the register selected by `awaddr[3:2]` is updated byte-wise per `wstrb`, and `bvalid` is set.
- `bvalid` holds until `bready`; it clears on the edge where `bvalid && bready`.
- No new write is accepted while `bvalid` is high.

Read path:
- `arready` pulses for one cycle when `arvalid && !arready && !rvalid`.
- On that edge, `rdata` latches the register selected by `araddr[3:2]` and `rvalid` is set.
- `rvalid` and `rdata` hold stable until `rready`.

Read and write channels are independent and may complete in the same cycle. If a read and a write hit the same register in the same cycle, the read returns the pre-write value.

PWM core:
- 16-bit counter `cnt` counts 0..`per_act`, then wraps to 0.
- At wrap, and on every cycle while `enable`=0, the active copies load from the registers: `per_act`←PERIOD[15:0], `cmpa_act`←CMPA[15:0], `cmpb_act`←CMPB[15:0].
- While `enable`=0: `cnt` is held at 0, `pwm_a`=`pwm_b`=0, and `period_irq`=0.
- `pwm_a` = `enable && (cnt < cmpa_act)`.
- `pwm_b` = `enable && ((cnt < cmpb_act) ^ invert_b)`.
- Both PWM outputs are registered.
- Compare ≥ period+1 gives 100% duty; compare 0 gives 0% duty.
- PERIOD=0 toggles nothing: the counter stays at 0 and `period_irq` is high every enabled cycle.

## Timing
- Reset values: all registers, active copies, `cnt`, `awready`, `wready`, `bvalid`, `arready`, `rvalid`, `rdata`, `pwm_a`, `pwm_b` and `period_irq` are 0.
- Write latency: with `awvalid`/`wvalid` high at cycle 0, ready is high in cycle 1 and `bvalid` is high in cycle 2. The register value is visible in cycle 2.
- Read latency: with `arvalid` high at cycle 0, `arready` is high in cycle 1 and `rvalid`/`rdata` are valid in cycle 2.
- PWM outputs lag `cnt` by one cycle. `period_irq` is high in the cycle after `cnt==per_act`.
- Reset asserted mid-transaction: all handshake outputs drop asynchronously. Partial writes are lost; no response is issued after reset.
- If AW arrives without W (or W without AW), the transfer waits and no ready is asserted.

## Structure
- Package `epwm_pkg` holds:
  - register offsets `EPWM_CTRL`, `EPWM_PERIOD`, `EPWM_CMPA`, `EPWM_CMPB`;
  - CTRL bit indices;
  - `AXI_RESP_OKAY`;
  - the 16-bit `cnt_t` typedef.
- Sub-module `epwm_core` contains the counter, shadow load and PWM compare. The top level contains only the AXI4-Lite slave logic and the register bank.

## Test plan
- Loopback: write 1,2,3,4 to 0x0,0x4,0x8,0xC, then read back in order → `rdata` = 1,2,3,4 and every response is OKAY.
- Strobes: write 0xFFFFFFFF to 0x8, then write 0x00000000 with `wstrb`=4'b0101 → read returns 0xFF00FF00.
- Backpressure: hold `bready`=0 for 10 cycles → `bvalid` stays high, a second write is not accepted (`awready`=0), and it completes after `bready` rises.
- PWM duty: PERIOD=9, CMPA=3, CMPB=5, CTRL=0x3 → `pwm_a` is high 3 of every 10 cycles, `pwm_b` is high 5 of every 10 cycles, and `period_irq` pulses every 10 cycles.
- Shadow update: with PERIOD=9/CMPA=3 running, write CMPA=7 when `cnt`=2 → the current period keeps 3 high cycles and the next period has 7.
- Reset mid-read: assert reset the cycle after `arready` → `rvalid`=0 immediately, and all registers read 0 after reset release.
